// File: rtl/sp_sram_arbiter_pkg.sv
// Shared helpers for the single-port SRAM arbiter and its round-robin core.
//   idx_w         : index width for n requesters, never less than 1 bit
//   onehot_to_idx : binary index of the set bit in a one-hot vector
package sp_sram_arbiter_pkg;

  // Upper bound on requesters handled by onehot_to_idx.
  localparam int MAX_PORTS = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The result is all-zero for an all-zero input. Callers qualify it with a
  // separate "any grant" term.
  function automatic logic [31:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++)
      if (oh[i]) idx = idx | 32'(i);
    return idx;
  endfunction

endpackage

// File: rtl/sp_sram_arbiter_rr.sv
// Round-robin arbiter with a rotating priority pointer.
// The search starts at the pointer and moves upward modulo NUM_PORTS.
// When advance_i is high and some port is granted, the pointer moves to
// the slot just after the winner.
//   clk_i, rst_ni : clock, async active-low reset (pointer -> 0)
//   req_i         : per-port request
//   advance_i     : commit this cycle's grant (rotate the pointer)
//   gnt_o         : one-hot grant, combinational from req_i and pointer
//   gnt_idx_o     : binary index of gnt_o (0 when there is no grant)
module rr_arbiter
  import sp_sram_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 advance_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     gnt_idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic             found;

  always_comb begin
    int sel;
    sel   = 0;
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel = (int'(ptr_q) + i) % NUM_PORTS;
      if (!found && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign gnt_idx_o = IDX_W'(onehot_to_idx(MAX_PORTS'(gnt_o)));

  // With a single port the wrap always fires, so the pointer stays at 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      ptr_q <= '0;
    else if (advance_i && found)
      ptr_q <= (gnt_idx_o == IDX_W'(NUM_PORTS-1)) ? '0 : gnt_idx_o + 1'b1;
  end

endmodule

// File: rtl/sp_sram_arbiter.sv
// Shares one single-port SRAM (one-cycle read latency) among NUM_PORTS
// requesters using a req/gnt/rvalid handshake.
//   clk_i, rst_ni       : clock, async active-low reset
//   req_i/we_i          : per-port request / write enable
//   addr_i/wdata_i/be_i : per-port payload, flat vectors with port 0 in the LSBs
//   gnt_o               : one-hot combinational grant
//   rvalid_o            : one-hot response, one cycle after the grant (reads and writes)
//   rdata_o             : SRAM read data sent to every port
//   sram_*              : SRAM macro pins; sram_rdata_i is valid the cycle after a read
module sp_sram_arbiter
  import sp_sram_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS  = 2,
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_WORDS  = 1024,
  localparam int ADDR_WIDTH = $clog2(NUM_WORDS),
  localparam int BE_W       = DATA_WIDTH / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_PORTS*BE_W-1:0]       be_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  output logic [NUM_PORTS-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            sram_req_o,
  output logic                            sram_we_o,
  output logic [ADDR_WIDTH-1:0]           sram_addr_o,
  output logic [DATA_WIDTH-1:0]           sram_wdata_o,
  output logic [BE_W-1:0]                 sram_be_o,
  input  logic [DATA_WIDTH-1:0]           sram_rdata_i
);

  localparam int IDX_W = idx_w(NUM_PORTS);

  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_v;
  logic [NUM_PORTS-1:0][BE_W-1:0]       be_v;
  logic [IDX_W-1:0]                     gnt_idx;
  logic [IDX_W-1:0]                     resp_id_q;
  logic                                 rvalid_q;

  assign addr_v  = addr_i;
  assign wdata_v = wdata_i;
  assign be_v    = be_i;

  // Every grant is a real SRAM access, so the pointer advances on any grant.
  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .advance_i (1'b1),
    .gnt_o     (gnt_o),
    .gnt_idx_o (gnt_idx)
  );

  assign sram_req_o = |gnt_o;

  // AND-OR mux on the one-hot grant. All fields default to 0 when there is
  // no grant, which keeps we/be inactive while idle.
  always_comb begin
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_o[p]) begin
        sram_we_o    = we_i[p];
        sram_addr_o  = addr_v[p];
        sram_wdata_o = wdata_v[p];
        sram_be_o    = be_v[p];
      end
    end
  end

  // Response tracking: one slot is enough because read latency is fixed at
  // one cycle. Reset drops any response still in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q  <= 1'b0;
      resp_id_q <= '0;
    end else begin
      rvalid_q <= sram_req_o;
      if (sram_req_o) resp_id_q <= gnt_idx;
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      rvalid_o[p] = rvalid_q && (resp_id_q == IDX_W'(p));
  end

  assign rdata_o = sram_rdata_i;

endmodule

// File: tb/tb_sp_sram_arbiter.sv
module tb_sp_sram_arbiter;

  localparam int NP = 2;
  localparam int DW = 32;
  localparam int NW = 1024;
  localparam int AW = 10;
  localparam int BW = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NP-1:0]          req, we;
  logic [NP-1:0][AW-1:0]  addr;
  logic [NP-1:0][DW-1:0]  wdata;
  logic [NP-1:0][BW-1:0]  be;
  logic [NP-1:0]          gnt, rvalid;
  logic [DW-1:0]          rdata;
  logic                   s_req, s_we;
  logic [AW-1:0]          s_addr;
  logic [DW-1:0]          s_wdata, s_rdata;
  logic [BW-1:0]          s_be;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sp_sram_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .sram_req_o(s_req), .sram_we_o(s_we), .sram_addr_o(s_addr),
    .sram_wdata_o(s_wdata), .sram_be_o(s_be), .sram_rdata_i(s_rdata)
  );

  // Behavioural single-port SRAM: byte-masked writes, registered read data.
  logic [DW-1:0] mem [NW];
  always @(posedge clk) begin
    if (s_req) begin
      if (s_we) begin
        for (int b = 0; b < BW; b++)
          if (s_be[b]) mem[s_addr][8*b +: 8] <= s_wdata[8*b +: 8];
      end else begin
        s_rdata <= mem[s_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
  endtask

  task automatic drive(input int p, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] e);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; be[p] = e;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #3;
    // Reset state
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_sreq", s_req, 0);
    chk("rst_swe", s_we, 0);
    chk("rst_sbe", s_be, 0);
    chk("rst_saddr", s_addr, 0);
    #10 rst_n = 1'b1;
    step();

    // Single write then read on port 0
    drive(0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
    #1;
    chk("wr_gnt", gnt, 2'b01);
    chk("wr_sreq", s_req, 1);
    chk("wr_swe", s_we, 1);
    chk("wr_saddr", s_addr, 5);
    chk("wr_swdata", s_wdata, 32'hDEADBEEF);
    chk("wr_sbe", s_be, 4'hF);
    step();
    chk("wr_rvalid", rvalid, 2'b01);
    drive(0, 1'b0, 10'd5, 32'h0, 4'hF);
    #1;
    chk("rd_gnt", gnt, 2'b01);
    chk("rd_swe", s_we, 0);
    step();
    chk("rd_rvalid", rvalid, 2'b01);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    idle();
    #1;
    chk("idle_gnt", gnt, 0);
    chk("idle_sreq", s_req, 0);
    step();
    chk("idle_rvalid", rvalid, 0);

    // Contention from reset: strict alternation 0,1,0,1,0,1
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    drive(0, 1'b0, 10'd5, 32'h0, 4'hF);
    drive(1, 1'b0, 10'd9, 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("cont_gnt%0d", i), gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0)
        chk($sformatf("cont_rv%0d", i), rvalid, (i % 2 == 0) ? 2'b10 : 2'b01);
      step();
    end
    idle();
    #1;
    chk("cont_rv_last", rvalid, 2'b10);
    step();

    // Byte enables: port0 writes twice, port1 reads back
    drive(0, 1'b1, 10'd9, 32'h11223344, 4'hF);
    step();
    drive(0, 1'b1, 10'd9, 32'hAABBCCDD, 4'b0101);
    #1;
    chk("be_gnt", gnt, 2'b01);
    chk("be_sbe", s_be, 4'b0101);
    step();
    idle();
    drive(1, 1'b0, 10'd9, 32'h0, 4'hF);
    #1;
    chk("be_rd_gnt", gnt, 2'b10);
    step();
    idle();
    chk("be_rvalid", rvalid, 2'b10);
    chk("be_rdata", rdata, 32'h11BB33DD);

    // Idle cycles keep the pointer: after a port1 grant, port0 wins next
    drive(1, 1'b0, 10'd5, 32'h0, 4'hF);
    #1;
    chk("hold_gnt1", gnt, 2'b10);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold_sreq%0d", i), s_req, 0);
      step();
    end
    drive(0, 1'b0, 10'd5, 32'h0, 4'hF);
    drive(1, 1'b0, 10'd5, 32'h0, 4'hF);
    #1;
    chk("hold_gnt_both", gnt, 2'b01);
    step();
    idle();

    // Set pointer to 0 through a lone port1 grant
    drive(1, 1'b0, 10'd5, 32'h0, 4'hF);
    step();
    idle();
    // Withdrawn request: port1 asks for a write and gives up before its grant
    drive(0, 1'b0, 10'd5, 32'h0, 4'hF);
    drive(1, 1'b1, 10'd9, 32'h00000BAD, 4'hF);
    #1;
    chk("wd_gnt0", gnt, 2'b01);
    step();
    req[1] = 1'b0;
    #1;
    chk("wd_gnt1", gnt, 2'b01);
    chk("wd_rv1", rvalid, 2'b01);
    chk("wd_rdata", rdata, 32'hDEADBEEF);
    step();
    idle();
    chk("wd_rv2", rvalid, 2'b01);
    drive(0, 1'b0, 10'd9, 32'h0, 4'hF);
    step();
    idle();
    chk("wd_rv3", rvalid, 2'b01);
    chk("wd_unchanged", rdata, 32'h11BB33DD);
    step();

    // Async reset between a read grant and its response
    drive(0, 1'b0, 10'd5, 32'h0, 4'hF);
    step();
    idle();
    chk("ar_rv_before", rvalid, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("ar_rv_dropped", rvalid, 0);
    chk("ar_gnt", gnt, 0);
    #1 rst_n = 1'b1;
    step();
    drive(0, 1'b0, 10'd5, 32'h0, 4'hF);
    drive(1, 1'b0, 10'd9, 32'h0, 4'hF);
    #1;
    chk("ar_first_gnt", gnt, 2'b01);
    step();
    #1;
    chk("ar_second_gnt", gnt, 2'b10);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sp_sram_arbiter.md
Name: sp_sram_arbiter

Overview:
- Round-robin arbiter sharing one single-port SRAM macro (sp_sram instance, one-cycle read latency) between NUM_PORTS requesters.
- Requester side uses a req/gnt/rvalid handshake. Memory side drives the SRAM req/we/addr/wdata/be pins and consumes rdata.
- Sits between the SoC interconnect slaves (e.g. instruction/data ports, DMA) and a shared scratchpad.

Parameters:
- NUM_PORTS, 2, number of requesters (>=1)
- DATA_WIDTH, 32, word width in bits (multiple of 8)
- NUM_WORDS, 1024, SRAM depth; ADDR_WIDTH = $clog2(NUM_WORDS)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NUM_PORTS  per-port request
- we_i  in  NUM_PORTS  per-port write enable
- addr_i  in  NUM_PORTS*ADDR_WIDTH  per-port word address, packed with port 0 in the LSBs
- wdata_i  in  NUM_PORTS*DATA_WIDTH  per-port write data
- be_i  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables
- gnt_o  out  NUM_PORTS  one-hot grant, combinational
- rvalid_o  out  NUM_PORTS  response valid, one-hot, one cycle after grant
- rdata_o  out  DATA_WIDTH  read data broadcast to all ports; meaningful only with rvalid
- sram_req_o  out  1  SRAM request
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  ADDR_WIDTH  SRAM address
- sram_wdata_o  out  DATA_WIDTH  SRAM write data
- sram_be_o  out  DATA_WIDTH/8  SRAM byte enables
- sram_rdata_i  in  DATA_WIDTH  SRAM read data, valid the cycle after a read request

Behaviour:
- Reset (async, rst_ni low): priority pointer = 0, rvalid_o = 0, resp_id register = 0. All combinational outputs are 0 while req_i = 0.
- Arbitration:
  - Each cycle, the grant goes to the first requesting port at or after the pointer, searching upward modulo NUM_PORTS.
  - gnt_o is combinational from req_i and the pointer. At most one bit is set.
  - No request: gnt_o = 0, sram_req_o = 0, pointer unchanged.
- Pointer update: on any grant to port k, pointer <= (k+1) mod NUM_PORTS on the next edge. Worst-case wait is NUM_PORTS-1 grants.
- Memory mux: sram_req_o = |gnt_o. we/addr/wdata/be are taken from the granted port. With no grant, sram_we_o = 0, sram_be_o = 0, and addr/wdata are don't-care and driven 0.
- Handshake:
  - A requester holds req and its payload stable until it sees gnt.
  - A transfer completes on the edge where req & gnt are both high.
  - A requester may keep req high for back-to-back transfers.
  - Dropping req before gnt is allowed; the request is simply withdrawn.
- Response:
  - One cycle after a grant to port k, rvalid_o[k] = 1 for exactly one cycle, for both reads and writes.
  - rdata_o = sram_rdata_i unconditionally. It is valid for reads only; for writes its value is unspecified and must be ignored.
- Throughput: one transfer per cycle. A grant in cycle t and another in t+1 produce rvalid in t+1 and t+2.
- Single-port constraint: exactly one SRAM access per cycle, so there is never a same-cycle read/write collision.
- Read-after-write: a read granted the cycle after a write to the same address returns the new data. This relies on SRAM write-first ordering of sequential accesses; no bypass is needed.
- Reset mid-operation: an in-flight response is dropped (rvalid cleared). The requester must reissue.
- NUM_PORTS = 1: degenerates to a pass-through with gnt_o = req_i and a constant pointer.

Decomposition:
- Package sp_sram_arbiter_pkg:
  - Function for the index width $clog2(NUM_PORTS) clamped to a minimum of 1.
  - Helper function onehot_to_idx.
  - No struct types; ports stay flat packed vectors.
- Sub-module rr_arbiter (parameter NUM_PORTS):
  - Inputs clk_i, rst_ni, req_i, advance_i. Outputs gnt_o (one-hot) and gnt_idx_o.
  - Holds the rotating pointer. Reusable for other shared macros.
- Top level holds the payload mux, resp_id/rvalid registers and the rdata broadcast.

Test Plan:
- Single read: port0 writes 0xDEADBEEF to addr 5 with be=0xF, then reads addr 5 -> gnt_o[0] same cycle; rvalid_o[0] next cycle; rdata_o = 0xDEADBEEF.
- Contention: ports 0 and 1 both request continuously for 6 cycles from reset -> grants 0,1,0,1,0,1; each rvalid follows its grant by 1 cycle; no cycle has two grants.
- Byte enables: write 0x11223344 to addr 9, then write 0xAABBCCDD with be=0b0101, then read addr 9 -> 0x11BB33DD.
- Idle/pointer hold: grant port1, leave 3 idle cycles, then both ports request -> port0 granted first; sram_req_o = 0 in the idle cycles.
- Withdrawn request: port1 raises req while port0 is granted, drops it next cycle before its grant -> no gnt/rvalid on port1; SRAM contents unchanged.
- Async reset: assert rst_ni low in the cycle between a read grant and its response -> rvalid_o = 0 immediately. After release, the pointer is 0 and the first grant goes to port0 when both ports request.
